// File: rtl/servo_pen_lift_ctrl.sv
// servo_pen_lift_ctrl: pen up/down command stage with mechanical settle hold-off.
// Optional macro SERVO_PEN_SKIP_SAME_EN: same-position commands skip the settle wait.
module servo_pen_lift_ctrl #(
  parameter int unsigned CLK_EN_DIV   = 5000,
  parameter int unsigned SETTLE_TICKS = 3000
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_pos,
  output logic servo_pos,
  output logic busy,
  output logic done
);

  localparam int unsigned PW = $clog2(CLK_EN_DIV);
  localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_EN_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [SW-1:0] SETL_LAST  = SW'(SETTLE_TICKS - 1);
  localparam logic [SW-1:0] SETL_ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [SW-1:0] settle_q;
  logic [SW-1:0] settle_d;
  logic          ready_q;
  logic          pos_q;
  logic          busy_q;
  logic          done_q;

  logic accept;
  logic tick;
  logic last_tick;

  // ready_q is only ever high in IDLE, so it alone qualifies the handshake
  assign accept    = cmd_valid && ready_q;
  assign tick      = (presc_q == PRESC_LAST);
  assign last_tick = tick && (settle_q == SETL_LAST);
  assign presc_d   = tick ? '0 : presc_q + PRESC_ONE;
  assign settle_d  = settle_q + SETL_ONE;

`ifdef SERVO_PEN_SKIP_SAME_EN
  logic same_pos;
  assign same_pos = (cmd_pos == pos_q);
`endif

  // Command FSM with all outputs registered; pen defaults to raised
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      settle_q <= '0;
      ready_q  <= 1'b0;
      pos_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            pos_q    <= cmd_pos;
            presc_q  <= '0;
            settle_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef SERVO_PEN_SKIP_SAME_EN
            if (same_pos) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SETTLE;
            end
`else
            state_q <= SETTLE;
`endif
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          presc_q <= presc_d;
          if (tick) begin
            settle_q <= settle_d;
          end
          if (last_tick) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign servo_pos = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_servo_pen_lift_ctrl.sv
// tb_servo_pen_lift_ctrl: vector table plus directed corner sequences
// with CLK_EN_DIV = 4, SETTLE_TICKS = 3 (settle = 12 cycles, done at T+13).
module tb_servo_pen_lift_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned ST  = 3;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_pos;
  logic servo_pos;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  servo_pen_lift_ctrl #(
    .CLK_EN_DIV  (DIV),
    .SETTLE_TICKS(ST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pos  (cmd_pos),
    .servo_pos(servo_pos),
    .busy     (busy),
    .done     (done)
  );

  // inputs for one cycle, outputs expected in the following cycle
  typedef struct packed {
    logic r;
    logic v;
    logic p;
    logic er;
    logic ep;
    logic eb;
    logic ed;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic add(input logic r, input logic v, input logic p,
                     input logic er, input logic ep,
                     input logic eb, input logic ed);
    vec_t e;
    e.r = r; e.v = v; e.p = p;
    e.er = er; e.ep = ep; e.eb = eb; e.ed = ed;
    vq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  int dones;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_pos   = 1'b0;

    // reset held 3 cycles, then release
    repeat (3) add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    // DOWN command, inputs toggled during SETTLE/DONE are ignored
    add(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++)
      add(0, logic'(i % 2), logic'((i / 2) % 2), 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 1);
    add(0, 1, 1, 1, 0, 0, 0);
    // UP accepted, valid held, then DOWN back-to-back
    add(0, 1, 1, 0, 1, 1, 0);
    repeat (11) add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 1, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    repeat (11) add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0);

    foreach (vq[i]) begin
      reset     = vq[i].r;
      cmd_valid = vq[i].v;
      cmd_pos   = vq[i].p;
      step();
      chk($sformatf("v%0d ready", i), 32'(cmd_ready), 32'(vq[i].er));
      chk($sformatf("v%0d pos", i),   32'(servo_pos), 32'(vq[i].ep));
      chk($sformatf("v%0d busy", i),  32'(busy),      32'(vq[i].eb));
      chk($sformatf("v%0d done", i),  32'(done),      32'(vq[i].ed));
    end

    // UP from DOWN: full settle, done at T+13
    cmd_valid = 1'b1;
    cmd_pos   = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("up_done_lat", 32'(n), 32'd13);
    chk("up_pos", 32'(servo_pos), 32'd1);
    step();
    chk("up_ready_after", 32'(cmd_ready), 32'd1);

    // same position UP again
    cmd_valid = 1'b1;
    cmd_pos   = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("same_busy", 32'(busy), 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
`ifdef SERVO_PEN_SKIP_SAME_EN
    chk("same_done_lat", 32'(n), 32'd1);
`else
    chk("same_done_lat", 32'(n), 32'd13);
`endif
    chk("same_pos", 32'(servo_pos), 32'd1);
    step();
    chk("same_ready_after", 32'(cmd_ready), 32'd1);

    // reset asserted at T+6 of a DOWN command
    cmd_valid = 1'b1;
    cmd_pos   = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("rst_t1_pos", 32'(servo_pos), 32'd0);
    repeat (5) step();
    chk("rst_t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_t7_pos",   32'(servo_pos), 32'd1);
    chk("rst_t7_busy",  32'(busy),      32'd0);
    chk("rst_t7_done",  32'(done),      32'd0);
    chk("rst_t7_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'd0);
    chk("rst_ready_idle", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
